// File: rtl/chunk_row_burst_if.sv
// Row-descriptor and burst-request handshake bundle for chunk_row_burst.
// slave = the splitter's view; master = upstream row source plus downstream burst sink.
interface chunk_row_burst_if #(
  parameter int unsigned GBW   = 32,
  parameter int unsigned VSIZE = 32,
  parameter int unsigned LENBW = 16
);
  localparam int unsigned V_BW = $clog2(VSIZE);

  logic             row_rdy;
  logic             row_ack;
  logic [GBW-1:0]   i_row_linear;
  logic [LENBW-1:0] i_row_len;
  logic             i_row_islast;
  logic [V_BW-1:0]  i_row_pad;
  logic             i_row_valid;

  logic             burst_rdy;
  logic             burst_ack;
  logic [GBW-1:0]   o_burst_addr;
  logic [V_BW-1:0]  o_burst_ofs;
  logic [V_BW-1:0]  o_burst_pad;
  logic             o_burst_skip;
  logic             o_burst_rlast;
  logic             o_burst_clast;

  modport slave (
    input  row_rdy, i_row_linear, i_row_len, i_row_islast, i_row_pad, i_row_valid,
    output row_ack,
    output burst_rdy, o_burst_addr, o_burst_ofs, o_burst_pad, o_burst_skip,
    output o_burst_rlast, o_burst_clast,
    input  burst_ack
  );

  modport master (
    output row_rdy, i_row_linear, i_row_len, i_row_islast, i_row_pad, i_row_valid,
    input  row_ack,
    input  burst_rdy, o_burst_addr, o_burst_ofs, o_burst_pad, o_burst_skip,
    input  o_burst_rlast, o_burst_clast,
    output burst_ack
  );
endinterface

// File: rtl/chunk_row_burst.sv
// Splits one row descriptor into VSIZE-aligned vector burst addresses; invalid rows become one skip token.
// Optional CHUNK_ROW_BURST_STAT_EN adds o_nburst, a saturating count of non-skip burst handshakes.
module chunk_row_burst #(
  parameter int unsigned GBW   = 32,
  parameter int unsigned VSIZE = 32,
  parameter int unsigned LENBW = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  chunk_row_burst_if.slave    bus
`ifdef CHUNK_ROW_BURST_STAT_EN
  ,
  output logic [31:0]         o_nburst
`endif
);

  localparam int unsigned V_BW = $clog2(VSIZE);
  localparam logic [GBW-1:0] MASK = GBW'(VSIZE - 1);
  localparam logic [GBW-1:0] STEP = GBW'(VSIZE);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e          state_q, state_d;
  logic            burst_rdy_q, burst_rdy_d;
  logic [GBW-1:0]  cur_q, cur_d;
  logic [GBW-1:0]  last_q, last_d;
  logic [V_BW-1:0] ofs_q, ofs_d;
  logic [V_BW-1:0] pad_q, pad_d;
  logic            skip_q, skip_d;
  logic            rlast_q, rlast_d;
  logic            islast_q, islast_d;

  logic [GBW-1:0]  row_first;
  logic [GBW-1:0]  row_end;
  logic [GBW-1:0]  row_lastaddr;
  logic [GBW-1:0]  cur_next;
  logic            row_skip;
  logic            fire;
  logic            row_ack;
  logic            load;

  always_comb begin
    row_first    = bus.i_row_linear & ~MASK;
    row_end      = bus.i_row_linear + GBW'(bus.i_row_len) - GBW'(1);
    row_lastaddr = row_end & ~MASK;
    row_skip     = ~bus.i_row_valid | (bus.i_row_len == '0);
    cur_next     = cur_q + STEP;
    fire         = burst_rdy_q & bus.burst_ack;
    // Accept the next row in the same cycle the final burst leaves; held low while in reset.
    row_ack      = i_rst & ((state_q == IDLE) | (fire & rlast_q));
    load         = bus.row_rdy & row_ack;

    state_d     = state_q;
    burst_rdy_d = burst_rdy_q;
    cur_d       = cur_q;
    last_d      = last_q;
    ofs_d       = ofs_q;
    pad_d       = pad_q;
    skip_d      = skip_q;
    rlast_d     = rlast_q;
    islast_d    = islast_q;

    if (load) begin
      state_d     = BURST;
      burst_rdy_d = 1'b1;
      cur_d       = row_first;
      last_d      = row_lastaddr;
      ofs_d       = bus.i_row_linear[V_BW-1:0];
      pad_d       = bus.i_row_pad;
      skip_d      = row_skip;
      rlast_d     = row_skip | (row_first == row_lastaddr);
      islast_d    = bus.i_row_islast;
    end else if (fire) begin
      if (rlast_q) begin
        state_d     = IDLE;
        burst_rdy_d = 1'b0;
      end else begin
        cur_d   = cur_next;
        ofs_d   = '0;
        rlast_d = (cur_next == last_q);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      burst_rdy_q <= 1'b0;
      cur_q       <= '0;
      last_q      <= '0;
      ofs_q       <= '0;
      pad_q       <= '0;
      skip_q      <= 1'b0;
      rlast_q     <= 1'b0;
      islast_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_rdy_q <= burst_rdy_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      ofs_q       <= ofs_d;
      pad_q       <= pad_d;
      skip_q      <= skip_d;
      rlast_q     <= rlast_d;
      islast_q    <= islast_d;
    end
  end

  assign bus.row_ack       = row_ack;
  assign bus.burst_rdy     = burst_rdy_q;
  assign bus.o_burst_addr  = cur_q;
  assign bus.o_burst_ofs   = ofs_q;
  assign bus.o_burst_pad   = pad_q;
  assign bus.o_burst_skip  = skip_q;
  assign bus.o_burst_rlast = rlast_q;
  assign bus.o_burst_clast = rlast_q & islast_q;

`ifdef CHUNK_ROW_BURST_STAT_EN
  logic [31:0] nburst_q, nburst_d;

  always_comb begin
    nburst_d = nburst_q;
    if (fire && !skip_q && (nburst_q != '1)) begin
      nburst_d = nburst_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      nburst_q <= '0;
    end else begin
      nburst_q <= nburst_d;
    end
  end

  assign o_nburst = nburst_q;
`endif

endmodule

// File: tb/tb_chunk_row_burst.sv
// Directed bench for chunk_row_burst (VSIZE=32): single/multi-burst rows, skip rows, stalls,
// back-to-back rows, address wrap and mid-row reset; expected bursts are hand-computed.
module tb_chunk_row_burst;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  chunk_row_burst_if #(.GBW(32), .VSIZE(32), .LENBW(16)) bus ();

`ifdef CHUNK_ROW_BURST_STAT_EN
  logic [31:0] nburst;
  chunk_row_burst #(.GBW(32), .VSIZE(32), .LENBW(16)) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus), .o_nburst(nburst)
  );
`else
  chunk_row_burst #(.GBW(32), .VSIZE(32), .LENBW(16)) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next falling edge: inputs are driven and outputs sampled there.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_row(input logic [31:0] lin, input logic [15:0] len,
                           input logic islast, input logic [4:0] pad, input logic valid);
    bus.i_row_linear = lin;
    bus.i_row_len    = len;
    bus.i_row_islast = islast;
    bus.i_row_pad    = pad;
    bus.i_row_valid  = valid;
    bus.row_rdy      = 1'b1;
  endtask

  // Present a row, wait (bounded) for row_ack, let the accepting edge pass, then drop row_rdy.
  task automatic send_row(input string tag, input logic [31:0] lin, input logic [15:0] len,
                          input logic islast, input logic [4:0] pad, input logic valid);
    bit seen;
    drive_row(lin, len, islast, pad, valid);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #0;
      if (bus.row_ack) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq({tag, "_row_ack"}, 64'(seen), 64'd1);
    tick();
    bus.row_rdy = 1'b0;
  endtask

  // Wait (bounded) for burst_rdy with burst_ack high, check the burst fields, then let it transfer.
  task automatic expect_burst(input string tag, input logic [31:0] addr, input logic [4:0] ofs,
                              input logic [4:0] pad, input logic skip, input logic rlast,
                              input logic clast);
    bit seen;
    bus.burst_ack = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #0;
      if (bus.burst_rdy) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq({tag, "_rdy"},   64'(seen), 64'd1);
    check_eq({tag, "_addr"},  64'(bus.o_burst_addr), 64'(addr));
    check_eq({tag, "_ofs"},   64'(bus.o_burst_ofs), 64'(ofs));
    check_eq({tag, "_pad"},   64'(bus.o_burst_pad), 64'(pad));
    check_eq({tag, "_skip"},  64'(bus.o_burst_skip), 64'(skip));
    check_eq({tag, "_rlast"}, 64'(bus.o_burst_rlast), 64'(rlast));
    check_eq({tag, "_clast"}, 64'(bus.o_burst_clast), 64'(clast));
    tick();
  endtask

`ifdef CHUNK_ROW_BURST_STAT_EN
  logic [31:0] cnt_before;
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.row_rdy   = 1'b0;
    bus.burst_ack = 1'b0;
    bus.i_row_linear = '0;
    bus.i_row_len    = '0;
    bus.i_row_islast = 1'b0;
    bus.i_row_pad    = '0;
    bus.i_row_valid  = 1'b0;

    tick();
    tick();
    check_eq("rst_burst_rdy", 64'(bus.burst_rdy), 64'd0);
    check_eq("rst_row_ack",   64'(bus.row_ack), 64'd0);
    check_eq("rst_addr",      64'(bus.o_burst_addr), 64'd0);
    check_eq("rst_clast",     64'(bus.o_burst_clast), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_row_ack", 64'(bus.row_ack), 64'd1);

    // Aligned single-vector row; burst valid one cycle after accept.
    bus.burst_ack = 1'b1;
    send_row("r1", 32'h40, 16'd32, 1'b0, 5'd3, 1'b1);
    check_eq("r1_latency", 64'(bus.burst_rdy), 64'd1);
    expect_burst("r1b0", 32'h40, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0);
    check_eq("r1_idle", 64'(bus.burst_rdy), 64'd0);

    // Unaligned row spanning two vectors, last of chunk.
    send_row("r2", 32'h45, 16'd40, 1'b1, 5'd9, 1'b1);
    expect_burst("r2b0", 32'h40, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    expect_burst("r2b1", 32'h60, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1);

    // Out-of-bound row: one skip token, counter unchanged.
`ifdef CHUNK_ROW_BURST_STAT_EN
    check_eq("stat_after_r2", 64'(nburst), 64'd3);
    cnt_before = nburst;
`endif
    send_row("r3", 32'h87, 16'd10, 1'b0, 5'd2, 1'b0);
    expect_burst("r3b0", 32'h80, 5'd7, 5'd2, 1'b1, 1'b1, 1'b0);
`ifdef CHUNK_ROW_BURST_STAT_EN
    check_eq("stat_skip", 64'(nburst), 64'(cnt_before));
`endif

    // Zero-length valid row also becomes a skip token.
    send_row("r4", 32'h123, 16'd0, 1'b1, 5'd0, 1'b1);
    expect_burst("r4b0", 32'h120, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1);

    // Three-burst row with a 5-cycle stall on the second burst.
    send_row("r5", 32'h100, 16'd96, 1'b0, 5'd1, 1'b1);
    expect_burst("r5b0", 32'h100, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    bus.burst_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq("r5_stall_rdy",   64'(bus.burst_rdy), 64'd1);
      check_eq("r5_stall_addr",  64'(bus.o_burst_addr), 64'h120);
      check_eq("r5_stall_rlast", 64'(bus.o_burst_rlast), 64'd0);
      tick();
    end
    expect_burst("r5b1", 32'h120, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    expect_burst("r5b2", 32'h140, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0);

    // Back-to-back rows with row_rdy held: next row loads on the last burst's ack.
    bus.burst_ack = 1'b1;
    drive_row(32'h200, 16'd64, 1'b0, 5'd4, 1'b1);
    #0;
    check_eq("b2b_a_ack", 64'(bus.row_ack), 64'd1);
    tick();
    drive_row(32'h300, 16'd1, 1'b1, 5'd6, 1'b1);
    #0;
    check_eq("b2b_mid_noack", 64'(bus.row_ack), 64'd0);
    check_eq("b2b_a0_addr", 64'(bus.o_burst_addr), 64'h200);
    tick();
    check_eq("b2b_a1_addr",  64'(bus.o_burst_addr), 64'h220);
    check_eq("b2b_a1_rlast", 64'(bus.o_burst_rlast), 64'd1);
    check_eq("b2b_last_ack", 64'(bus.row_ack), 64'd1);
    tick();
    bus.row_rdy = 1'b0;
    check_eq("b2b_b_rdy", 64'(bus.burst_rdy), 64'd1);
    expect_burst("b2b_b0", 32'h300, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1);
    check_eq("b2b_idle", 64'(bus.burst_rdy), 64'd0);

    // Address wrap: end address crosses 2^32, last vector is 0.
    send_row("r6", 32'hFFFF_FFF0, 16'd32, 1'b0, 5'd0, 1'b1);
    expect_burst("r6b0", 32'hFFFF_FFE0, 5'd16, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_burst("r6b1", 32'h0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Reset during the second burst of a three-burst row.
    send_row("r7", 32'h400, 16'd96, 1'b1, 5'd5, 1'b1);
    expect_burst("r7b0", 32'h400, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    check_eq("r7b1_addr", 64'(bus.o_burst_addr), 64'h420);
    rst_n = 1'b0;
    #1;
    check_eq("r7_rst_rdy",  64'(bus.burst_rdy), 64'd0);
    check_eq("r7_rst_ack",  64'(bus.row_ack), 64'd0);
    check_eq("r7_rst_addr", 64'(bus.o_burst_addr), 64'd0);
`ifdef CHUNK_ROW_BURST_STAT_EN
    check_eq("stat_rst", 64'(nburst), 64'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_rdy", 64'(bus.burst_rdy), 64'd0);
    check_eq("post_rst_ack", 64'(bus.row_ack), 64'd1);
    send_row("r8", 32'h500, 16'd5, 1'b0, 5'd0, 1'b1);
    expect_burst("r8b0", 32'h500, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_eq("r8_idle", 64'(bus.burst_rdy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
